// File: rtl/lc3_pc_pkg.sv
// Shared types and constants for the LC-3 program-counter unit.
package lc3_pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_INC = 2'b00,
    PC_SEL_EAB = 2'b01,
    PC_SEL_BUS = 2'b10,
    PC_SEL_RAS = 2'b11
  } pc_sel_t;

  localparam int unsigned PC_WIDTH     = 16;
  localparam logic [15:0] PC_RESET_VEC = 16'h3000;

endpackage

// File: rtl/pc_ras.sv
// Circular hardware return-address stack with entry count and sticky overflow/underflow flags.
module pc_ras #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             pop,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr, ptr_nxt, ptr_m1, wr_addr;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt, unf_nxt, wr_en, full;

  // ptr is the next free slot; the top of stack sits just below it.
  assign ptr_m1  = ptr - PTR_W'(1);
  assign full    = (cnt == CNT_W'(RAS_DEPTH));
  assign empty_c = (cnt == '0);
  assign top_c   = mem[ptr_m1];

  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    ovf_nxt = clr_err ? 1'b0 : ovf;
    unf_nxt = clr_err ? 1'b0 : unf;
    wr_en   = 1'b0;
    wr_addr = ptr;
    if (ld) begin
      if (pop && !empty_c) begin
        if (push) begin
          // Return and call in one cycle: replace the top in place.
          wr_en   = 1'b1;
          wr_addr = ptr_m1;
        end else begin
          ptr_nxt = ptr_m1;
          cnt_nxt = cnt - CNT_W'(1);
        end
      end else begin
        if (pop) unf_nxt = 1'b1;
        if (push) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + PTR_W'(1);
          if (full) ovf_nxt = 1'b1;
          else      cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  // Stack data needs no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= push_data;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// LC-3 PC register with next-PC mux (PC+1 / EAB / bus / return stack).
// Optional last-branch-source trace register enabled by PC_TRACE_EN.
module pc_unit_ras
  import lc3_pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter int unsigned       RAS_DEPTH = 4,
  localparam int unsigned      CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ldPC,
  input  logic [1:0]       selPC,
  input  logic             push,
  input  logic [WIDTH-1:0] eabOut,
  input  logic [WIDTH-1:0] Bus,
  input  logic             clr_err,
  output logic [WIDTH-1:0] PCOut,
`ifdef PC_TRACE_EN
  output logic [WIDTH-1:0] trace_pc,
`endif
  output logic [CNT_W-1:0] ras_cnt,
  output logic             ras_ovf,
  output logic             ras_unf
);

  pc_sel_t          sel;
  logic [WIDTH-1:0] pc_inc, pc_nxt, ras_top;
  logic             ras_empty, pc_load;

  assign sel    = pc_sel_t'(selPC);
  assign pc_inc = PCOut + WIDTH'(1);

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .ld        (ldPC),
    .pop       (sel == PC_SEL_RAS),
    .push      (push),
    .push_data (pc_inc),
    .clr_err   (clr_err),
    .top_c     (ras_top),
    .empty_c   (ras_empty),
    .cnt       (ras_cnt),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  // A pop from an empty stack leaves the PC where it is.
  always_comb begin
    pc_nxt  = PCOut;
    pc_load = 1'b0;
    if (ldPC) begin
      unique case (sel)
        PC_SEL_INC: begin pc_nxt = pc_inc; pc_load = 1'b1; end
        PC_SEL_EAB: begin pc_nxt = eabOut; pc_load = 1'b1; end
        PC_SEL_BUS: begin pc_nxt = Bus;    pc_load = 1'b1; end
        PC_SEL_RAS: begin
          if (!ras_empty) begin
            pc_nxt  = ras_top;
            pc_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) PCOut <= RESET_VEC;
    else        PCOut <= pc_nxt;
  end

`ifdef PC_TRACE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             trace_pc <= '0;
    else if (pc_load && sel != PC_SEL_INC)  trace_pc <= PCOut;
  end
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed self-checking bench for pc_unit_ras (default parameters; honours PC_TRACE_EN).
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic        ldPC;
  logic [1:0]  selPC;
  logic        push;
  logic [15:0] eabOut;
  logic [15:0] Bus;
  logic        clr_err;
  logic [15:0] PCOut;
  logic [2:0]  ras_cnt;
  logic        ras_ovf;
  logic        ras_unf;
`ifdef PC_TRACE_EN
  logic [15:0] trace_pc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_unit_ras dut (
    .clk      (clk),
    .reset    (reset),
    .ldPC     (ldPC),
    .selPC    (selPC),
    .push     (push),
    .eabOut   (eabOut),
    .Bus      (Bus),
    .clr_err  (clr_err),
    .PCOut    (PCOut),
`ifdef PC_TRACE_EN
    .trace_pc (trace_pc),
`endif
    .ras_cnt  (ras_cnt),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic ld, input logic [1:0] sel, input logic psh,
                     input logic [15:0] eab, input logic [15:0] bus, input logic clr);
    ldPC = ld; selPC = sel; push = psh; eabOut = eab; Bus = bus; clr_err = clr;
    @(posedge clk);
    #1;
    ldPC = 1'b0; push = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_ras(input string tag, input logic [15:0] pc, input int cnt,
                         input logic ovf, input logic unf);
    chk({tag, "_pc"},  32'(PCOut),   32'(pc));
    chk({tag, "_cnt"}, 32'(ras_cnt), 32'(cnt));
    chk({tag, "_ovf"}, 32'(ras_ovf), 32'(ovf));
    chk({tag, "_unf"}, 32'(ras_unf), 32'(unf));
  endtask

  initial begin
    reset = 1'b0; ldPC = 1'b0; selPC = 2'b00; push = 1'b0;
    eabOut = '0; Bus = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_ras("reset", 16'h3000, 0, 1'b0, 1'b0);
`ifdef PC_TRACE_EN
    chk("trace_reset", 32'(trace_pc), 32'h0);
`endif

    // Asynchronous reset mid-cycle, and an edge during reset must not load.
    cyc(1'b1, 2'b10, 1'b0, 16'h0, 16'h5555, 1'b0);
    chk("bus_load", 32'(PCOut), 32'h5555);
    #2 reset = 1'b0;
    #1 chk("async_reset", 32'(PCOut), 32'h3000);
    ldPC = 1'b1; selPC = 2'b10; Bus = 16'h7777;
    @(posedge clk); #1;
    chk("reset_hold", 32'(PCOut), 32'h3000);
    ldPC = 1'b0;
    reset = 1'b1;

    cyc(1'b1, 2'b00, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("inc", 32'(PCOut), 32'h3001);

    cyc(1'b1, 2'b10, 1'b0, 16'h0, 16'hFFFF, 1'b0);
    chk("load_ffff", 32'(PCOut), 32'hFFFF);
`ifdef PC_TRACE_EN
    chk("trace_bus", 32'(trace_pc), 32'h3001);
`endif
    cyc(1'b1, 2'b00, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("wrap", 32'(PCOut), 32'h0000);
`ifdef PC_TRACE_EN
    chk("trace_inc_hold", 32'(trace_pc), 32'h3001);
`endif

    // Call / return
    cyc(1'b1, 2'b10, 1'b0, 16'h0, 16'h3005, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 16'h4000, 16'h0, 1'b0);
    chk_ras("call", 16'h4000, 1, 1'b0, 1'b0);
`ifdef PC_TRACE_EN
    chk("trace_call", 32'(trace_pc), 32'h3005);
`endif
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("ret", 16'h3006, 0, 1'b0, 1'b0);
`ifdef PC_TRACE_EN
    chk("trace_ret", 32'(trace_pc), 32'h4000);
`endif

    // Overflow: five calls at depth 4; returns 1001..1041, oldest (1001) overwritten.
    cyc(1'b1, 2'b10, 1'b0, 16'h0, 16'h1000, 1'b0);
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 2'b10, 1'b1, 16'h0, 16'(16'h1000 + 16'(i * 16)), 1'b0);
    chk_ras("ovf", 16'h1050, 4, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("pop1", 16'h1041, 3, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("pop2", 16'h1031, 2, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("pop3", 16'h1021, 1, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("pop4", 16'h1011, 0, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("pop5", 16'h1011, 0, 1'b1, 1'b1);

    // Hold with ldPC=0, then clear flags without ldPC
    cyc(1'b0, 2'b10, 1'b1, 16'h0, 16'hABCD, 1'b0);
    chk_ras("hold", 16'h1011, 0, 1'b1, 1'b1);
    cyc(1'b0, 2'b10, 1'b0, 16'h0, 16'hABCD, 1'b1);
    chk_ras("clr", 16'h1011, 0, 1'b0, 1'b0);

    // Replace: cnt=2, top=3100, PC=3200
    cyc(1'b1, 2'b10, 1'b0, 16'h0, 16'h3050, 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 16'h0, 16'h30FF, 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 16'h0, 16'h3200, 1'b0);
    chk_ras("pre_repl", 16'h3200, 2, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 16'h0, 16'h0, 1'b0);
    chk_ras("repl", 16'h3100, 2, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("repl_pop1", 16'h3201, 1, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("repl_pop2", 16'h3051, 0, 1'b0, 1'b0);

    // Push + pop on empty stack with clr_err: flag set wins, push proceeds
    cyc(1'b1, 2'b11, 1'b1, 16'h0, 16'h0, 1'b1);
    chk_ras("push_pop_empty", 16'h3051, 1, 1'b0, 1'b1);
    cyc(1'b1, 2'b11, 1'b0, 16'h0, 16'h0, 1'b0);
    chk_ras("pop_after", 16'h3052, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
